// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch unit and memory.
//   imem_req_valid : request valid (fetch -> memory)
//   imem_req_addr  : request word address (fetch -> memory)
//   imem_req_ready : memory accepts the request when valid & ready (memory -> fetch)
//   imem_rsp_valid : one-cycle response pulse per accepted request (memory -> fetch)
//   imem_rsp_data  : fetched instruction word (memory -> fetch)
interface fetch_unit_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage with a single outstanding memory request and a decode-stage register.
//   clk       : clock, all state updates on the rising edge
//   reset     : asynchronous active-low reset
//   StallF    : suppresses issue of new fetch requests
//   StallD    : holds the decode-stage register
//   FlushD    : replaces the decode-stage register with a bubble (beats StallD and delivery)
//   PCSrcE    : taken branch/jump from execute; PCTargetE is the redirect address
//   imem      : instruction-memory channel (master side)
//   PCF       : next fetch address
//   InstrD, PCD, PCPlus4D, ValidD : decode-stage register contents
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         StallF,
  input  logic         StallD,
  input  logic         FlushD,
  input  logic         PCSrcE,
  input  logic [31:0]  PCTargetE,
  fetch_unit_if.master imem,
  output logic [31:0]  PCF,
  output logic [31:0]  InstrD,
  output logic [31:0]  PCD,
  output logic [31:0]  PCPlus4D,
  output logic         ValidD
);

  localparam logic [31:0] Nop = 32'h0000_0013;

  typedef enum logic [1:0] {
    StReq,
    StWait,
    StHold
  } state_e;

  state_e      r_state, w_state_next;
  logic        r_drop, w_drop_next;
  logic [31:0] r_pcf;
  logic [31:0] r_req_pc;
  logic [31:0] r_hold_instr;
  logic [31:0] r_hold_pc;
  logic [31:0] r_instr_d, r_pc_d, r_pc4_d;
  logic        r_valid_d;

  logic        w_req_valid;
  logic        w_fire;
  logic        w_deliver;
  logic        w_capture;
  logic [31:0] w_deliver_instr;
  logic [31:0] w_deliver_pc;

  // Request valid is the only combinational output: state, StallF and PCSrcE only.
  assign w_req_valid         = (r_state == StReq) && !StallF && !PCSrcE;
  assign w_fire              = w_req_valid && imem.imem_req_ready;
  assign imem.imem_req_valid = w_req_valid;
  assign imem.imem_req_addr  = r_pcf;

  always_comb begin
    w_state_next    = r_state;
    w_drop_next     = r_drop;
    w_deliver       = 1'b0;
    w_capture       = 1'b0;
    w_deliver_instr = r_hold_instr;
    w_deliver_pc    = r_hold_pc;
    unique case (r_state)
      StReq: begin
        if (w_fire) w_state_next = StWait;
      end
      StWait: begin
        if (imem.imem_rsp_valid) begin
          // Any response ends the transaction; it survives only if not killed by an earlier
          // redirect (drop), a same-cycle redirect, or a decode flush.
          w_state_next = StReq;
          w_drop_next  = 1'b0;
          if (!r_drop && !PCSrcE && !FlushD) begin
            if (StallD) begin
              w_capture    = 1'b1;
              w_state_next = StHold;
            end else begin
              w_deliver       = 1'b1;
              w_deliver_instr = imem.imem_rsp_data;
              w_deliver_pc    = r_req_pc;
            end
          end
        end else if (PCSrcE) begin
          w_drop_next = 1'b1;
        end
      end
      StHold: begin
        if (PCSrcE || FlushD) begin
          w_state_next = StReq;
        end else if (!StallD) begin
          w_deliver    = 1'b1;
          w_state_next = StReq;
        end
      end
      default: w_state_next = StReq;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= StReq;
      r_drop       <= 1'b0;
      r_pcf        <= RESET_PC;
      r_req_pc     <= 32'h0;
      r_hold_instr <= Nop;
      r_hold_pc    <= 32'h0;
    end else begin
      r_state <= w_state_next;
      r_drop  <= w_drop_next;
      // Redirect overrides the sequential increment.
      if (PCSrcE) begin
        r_pcf <= PCTargetE;
      end else if (w_fire) begin
        r_pcf <= r_pcf + 32'd4;
      end
      if (w_fire) r_req_pc <= r_pcf;
      if (w_capture) begin
        r_hold_instr <= imem.imem_rsp_data;
        r_hold_pc    <= r_req_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr_d <= Nop;
      r_pc_d    <= 32'h0;
      r_pc4_d   <= 32'h0;
      r_valid_d <= 1'b0;
    end else if (FlushD) begin
      r_instr_d <= Nop;
      r_valid_d <= 1'b0;
    end else if (!StallD) begin
      if (w_deliver) begin
        r_instr_d <= w_deliver_instr;
        r_pc_d    <= w_deliver_pc;
        r_pc4_d   <= w_deliver_pc + 32'd4;
        r_valid_d <= 1'b1;
      end else begin
        // Bubble keeps the PCs of the last real instruction.
        r_instr_d <= Nop;
        r_valid_d <= 1'b0;
      end
    end
  end

  assign PCF      = r_pcf;
  assign InstrD   = r_instr_d;
  assign PCD      = r_pc_d;
  assign PCPlus4D = r_pc4_d;
  assign ValidD   = r_valid_d;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by randomized hazard,
// redirect and memory-timing stimulus, checked against a transaction-level reference model.
module tb_fetch_unit;

  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam logic [31:0] Nop     = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0;
  logic [31:0] PCTargetE = 32'h0;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D;
  logic        ValidD;

  fetch_unit_if imem_if ();

  fetch_unit #(.RESET_PC(ResetPc)) dut (
    .clk      (clk),
    .reset    (reset),
    .StallF   (StallF),
    .StallD   (StallD),
    .FlushD   (FlushD),
    .PCSrcE   (PCSrcE),
    .PCTargetE(PCTargetE),
    .imem     (imem_if),
    .PCF      (PCF),
    .InstrD   (InstrD),
    .PCD      (PCD),
    .PCPlus4D (PCPlus4D),
    .ValidD   (ValidD)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   edge_cnt = 0;

  // Reference model: fetch PC, the one request in flight, a killed-by-redirect flag, and one
  // response parked while decode is stalled.
  logic [31:0] m_pc, m_out_pc, m_held_pc;
  bit          m_out, m_drop, m_held;
  logic [31:0] last_instr, last_pc, last_pc4;
  logic        last_valid;

  // Memory model.
  bit          mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00A0_0113;
    return {a[31:2], 2'b11} ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = ResetPc;
    m_out = 1'b0;
    m_drop = 1'b0;
    m_held = 1'b0;
    exp_q.delete();
    last_instr = Nop;
    last_pc = 32'h0;
    last_pc4 = 32'h0;
    last_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_q.push_back('{instr: mem_word(pc), pc: pc, pc4: pc + 32'd4, cyc: edge_cnt + 1});
  endtask

  // Called at a falling edge; drives one cycle of inputs, predicts the coming rising edge,
  // and returns at the next falling edge.
  task automatic step(input bit stf, input bit std, input bit fld, input bit pcs,
                      input logic [31:0] tgt, input bit rdy, input int lat,
                      input bit rst_n_val, input bit rst_mid);
    bit rsp;
    bit rdy_drv;
    bit exp_rv;
    bit fire;
    reset = rst_n_val;
    rsp = 1'b0;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        rsp = 1'b1;
        mem_busy = 1'b0;
      end
    end
    rdy_drv = rdy && rst_n_val && !mem_busy && !rsp;
    imem_if.imem_rsp_valid = rsp;
    imem_if.imem_rsp_data  = rsp ? mem_word(mem_addr) : 32'hDEAD_BEEF;
    imem_if.imem_req_ready = rdy_drv;
    StallF = stf;
    StallD = std;
    FlushD = fld;
    PCSrcE = pcs;
    PCTargetE = tgt;
    #1;
    exp_rv = !m_out && !m_held && !stf && !pcs;
    chk("req_valid", {31'b0, imem_if.imem_req_valid}, {31'b0, exp_rv});
    if (exp_rv) chk("req_addr", imem_if.imem_req_addr, m_pc);
    fire = exp_rv && rdy_drv;
    if (rst_n_val) begin
      if (m_out && rsp) begin
        m_out = 1'b0;
        if (m_drop) begin
          m_drop = 1'b0;
        end else if (!pcs && !fld) begin
          if (std) begin
            m_held = 1'b1;
            m_held_pc = m_out_pc;
          end else begin
            push_exp(m_out_pc);
          end
        end
      end else if (m_out && pcs) begin
        m_drop = 1'b1;
      end else if (m_held) begin
        if (pcs || fld) begin
          m_held = 1'b0;
        end else if (!std) begin
          push_exp(m_held_pc);
          m_held = 1'b0;
        end
      end
      if (fire) begin
        m_out = 1'b1;
        m_out_pc = m_pc;
        mem_busy = 1'b1;
        mem_cnt = lat;
        mem_addr = m_pc;
        m_pc = m_pc + 32'd4;
      end
      if (pcs) m_pc = tgt;
    end
    if (rst_mid) begin
      #2;
      reset = 1'b0;
      imem_if.imem_req_ready = 1'b0;
      #1;
      chk("async_rst_pcf", PCF, ResetPc);
      chk("async_rst_instr", InstrD, Nop);
      chk("async_rst_valid", {31'b0, ValidD}, 32'h0);
      chk("async_rst_pcd", PCD, 32'h0);
      chk("async_rst_pc4", PCPlus4D, 32'h0);
      model_reset();
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit std, input int lat);
    step(1'b0, std, 1'b0, 1'b0, 32'h0, 1'b1, lat, 1'b1, 1'b0);
  endtask

  // Monitor: samples after each rising edge and retires expected deliveries from the queue.
  always @(posedge clk) begin
    edge_cnt++;
    #2;
    if (reset) begin
      chk("pcf", PCF, m_pc);
      if (FlushD) chk("flush_valid", {31'b0, ValidD}, 32'h0);
      if (StallD && !FlushD) begin
        chk("hold_instr", InstrD, last_instr);
        chk("hold_pcd", PCD, last_pc);
        chk("hold_pc4", PCPlus4D, last_pc4);
        chk("hold_valid", {31'b0, ValidD}, {31'b0, last_valid});
      end else if (ValidD === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_delivery: got instr %h pc %h expected no delivery", InstrD, PCD);
        end else begin
          mon_e = exp_q.pop_front();
          chk("deliv_instr", InstrD, mon_e.instr);
          chk("deliv_pcd", PCD, mon_e.pc);
          chk("deliv_pc4", PCPlus4D, mon_e.pc4);
          chk("deliv_cycle", 32'(edge_cnt), 32'(mon_e.cyc));
          last_instr = mon_e.instr;
          last_pc = mon_e.pc;
          last_pc4 = mon_e.pc4;
          last_valid = 1'b1;
        end
      end else begin
        chk("bubble_instr", InstrD, Nop);
        chk("bubble_pcd", PCD, last_pc);
        chk("bubble_pc4", PCPlus4D, last_pc4);
        if (exp_q.size() > 0 && exp_q[0].cyc <= edge_cnt) begin
          mon_e = exp_q.pop_front();
          checks++;
          failures++;
          $display("FAIL missed_delivery: got ValidD=0 expected pc %h at edge %0d",
                   mon_e.pc, mon_e.cyc);
        end
        last_instr = Nop;
        last_valid = 1'b0;
      end
    end
  end

  initial begin
    bit stf, std, fld, pcs, rdy, rn, mid;
    logic [31:0] tgt;
    imem_if.imem_req_ready = 1'b0;
    imem_if.imem_rsp_valid = 1'b0;
    imem_if.imem_rsp_data  = 32'h0;
    model_reset();
    @(negedge clk);
    chk("reset_pcf", PCF, ResetPc);
    chk("reset_instr", InstrD, Nop);
    chk("reset_valid", {31'b0, ValidD}, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1, 1'b0, 1'b0);

    // Back-to-back fetch of 0x0 and 0x4, the second parked by a 3-cycle decode stall.
    idle(1'b0, 1);
    idle(1'b0, 1);
    idle(1'b0, 1);
    idle(1'b1, 1);
    idle(1'b1, 1);
    idle(1'b1, 1);
    idle(1'b0, 1);
    // Redirect to 0x40 while waiting on a slow response.
    idle(1'b0, 3);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 1, 1'b1, 1'b0);
    idle(1'b0, 1);
    idle(1'b0, 1);
    idle(1'b0, 1);
    // Flush and stall together on the response cycle.
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1, 1'b1, 1'b0);
    // Fetch at the top of the address space.
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1, 1'b1, 1'b0);
    idle(1'b0, 1);
    idle(1'b0, 1);
    idle(1'b0, 1);

    for (int i = 0; i < 2500; i++) begin
      stf = ($urandom_range(0, 4) == 0);
      std = ($urandom_range(0, 4) == 0);
      fld = ($urandom_range(0, 11) == 0);
      pcs = ($urandom_range(0, 11) == 0);
      tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & ~32'h3);
      rdy = ($urandom_range(0, 9) < 7);
      mid = (i == 1200);
      rn  = !(i > 1200 && i <= 1202);
      step(stf, std, fld, pcs, tgt, rdy, $urandom_range(1, 3), rn, mid);
    end

    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1, 1'b1, 1'b0);
    end
    chk("leftover_expected", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, the first fetch address after reset SHALL be this value.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 SHALL force reset state immediately.
REQ-004 StallF  input  1  from hazard unit; SHALL suppress issue of new fetch requests.
REQ-005 StallD  input  1  from hazard unit; SHALL hold the decode-stage register.
REQ-006 FlushD  input  1  from hazard unit; SHALL replace the decode-stage register with a bubble.
REQ-007 PCSrcE  input  1  from execute-stage control; taken branch or jump.
REQ-008 PCTargetE  input  32  redirect address, valid when PCSrcE=1.
REQ-009 imem_req_valid  output  1  instruction-memory request valid.
REQ-010 imem_req_addr  output  32  request word address, equal to PCF.
REQ-011 imem_req_ready  input  1  memory accepts request when valid&ready.
REQ-012 imem_rsp_valid  input  1  response data valid, one pulse per accepted request.
REQ-013 imem_rsp_data  input  32  fetched instruction.
REQ-014 PCF  output  32  next fetch address.
REQ-015 InstrD, PCD, PCPlus4D  output  32 each  decode-stage register contents.
REQ-016 ValidD  output  1  1 = decode-stage register holds a real instruction.

Function
REQ-017 Block SHALL allow at most one outstanding memory request.
REQ-018 FSM states SHALL be REQ (may issue), WAIT (request outstanding), HOLD (response buffered, decode stalled).
REQ-019 In REQ, imem_req_valid SHALL be 1 unless StallF=1 or PCSrcE=1.
REQ-020 On valid&ready: reqPC<=PCF, PCF<=PCF+4 (modulo 2^32, wraps to 0), state<=WAIT.
REQ-021 In WAIT with rsp_valid=1, drop=0, PCSrcE=0, StallD=0: load InstrD<=rsp_data, PCD<=reqPC, PCPlus4D<=reqPC+4, ValidD<=1, state<=REQ.
REQ-022 Same as REQ-021 but StallD=1: response SHALL be captured in a 1-entry hold buffer with reqPC, state<=HOLD.
REQ-023 In HOLD when StallD=0 and PCSrcE=0: decode register SHALL load from hold buffer, state<=REQ.
REQ-024 Response latency: rsp accepted in cycle C SHALL appear on InstrD/ValidD in cycle C+1 (zero buffering when not stalled).
REQ-025 PCSrcE=1 in any state SHALL set PCF<=PCTargetE at the next edge, overriding REQ-020 increment.
REQ-026 PCSrcE=1 in WAIT without rsp_valid SHALL set drop<=1; the next response SHALL be discarded, drop<=0, state<=REQ.
REQ-027 PCSrcE=1 in WAIT with rsp_valid same cycle, or in HOLD, SHALL discard that instruction and set state<=REQ.
REQ-028 Decode register with no new delivery and StallD=0 SHALL load bubble: InstrD<=32'h0000_0013, ValidD<=0, PCD/PCPlus4D unchanged.
REQ-029 StallD=1 SHALL hold InstrD, PCD, PCPlus4D, ValidD unchanged.
REQ-030 FlushD=1 SHALL load bubble, taking priority over StallD and over any delivery; a delivered response SHALL be discarded.
REQ-031 StallF SHALL not affect WAIT or HOLD progress.
REQ-032 Outputs other than imem_req_valid SHALL be registered; imem_req_valid SHALL depend only on state, StallF, PCSrcE.

Reset
REQ-033 reset=0 SHALL asynchronously set PCF=RESET_PC, state=REQ, drop=0, InstrD=32'h0000_0013, PCD=0, PCPlus4D=0, ValidD=0, hold buffer empty.
REQ-034 Reset mid-transaction SHALL abandon the outstanding request; a response arriving after reset release with state REQ SHALL be ignored.
REQ-035 First request SHALL be issued in the first cycle after reset release with StallF=0.

Verification
REQ-036 Reset release, ready=1, 1-cycle memory returning 0x00500093 -> imem_req_addr=0x0, two cycles later InstrD=0x00500093, PCD=0, PCPlus4D=4, ValidD=1, PCF=4.
REQ-037 StallD=1 during response 0x00A00113 at PC 0x4 for 3 cycles -> state HOLD, decode unchanged; on StallD=0 next edge InstrD=0x00A00113, PCD=4.
REQ-038 PCSrcE=1, PCTargetE=0x40 while WAIT -> following response discarded, next request addr=0x40, ValidD=0 meanwhile.
REQ-039 FlushD=1 and StallD=1 together with response -> InstrD=0x00000013, ValidD=0, response lost.
REQ-040 PCF=0xFFFFFFFC request accepted -> PCF=0x0, PCPlus4D=0x0 on delivery.
REQ-041 reset=0 asserted mid-cycle in WAIT -> outputs immediately at reset values without a clock edge.
